riot_bus_arbiter: RTL and testbench
===================================

RIOT_BUS_ARBITER -- requirements
Module: riot_bus_arbiter

Interface
REQ-001 SHALL have parameter: LOCK_MAX, 4'd15, maximum consecutive locked transactions before forced release (used only with RIOT_ARB_LOCK_EN).
REQ-002 SHALL have ports:
- phi2  in  1  clock
- rst  in  1  asynchronous active-high reset
- req  in  2  per-requester request, level, held until ack
- rq_we_n  in  2  per-requester write strobe, low = write
- rq_addr0/rq_addr1  in  10 each  requester address
- rq_wdata0/rq_wdata1  in  8 each  requester write data
- ack  out  2  one-cycle completion pulse per requester
- rdata  out  8  read data, valid while ack is high
- gnt_id  out  1  index of the current or last granted requester
- m_cs  out  1  bus access valid toward the 6530 core
- m_we_n  out  1  core RW
- m_A  out  10  core address
- m_DI  out  8  core write data
- m_DO  in  8  core read data
- m_OE  in  1  core read-data-valid
- lock  in  2  per-requester lock request (present only with RIOT_ARB_LOCK_EN)

Function
REQ-003 SHALL implement FSM IDLE -> ADDR -> DATA -> ACK -> IDLE, one state per phi2 cycle.
REQ-004 In IDLE with any req high, SHALL select a winner, latch its we_n/addr/wdata, and enter ADDR; with no req it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: a lone requester wins; on a tie the requester not granted last wins.
REQ-006 In ADDR, m_cs SHALL be 1 and m_we_n/m_A/m_DI SHALL carry the latched values; in all other states m_cs=0 and m_we_n=1, with m_A/m_DI holding their last values.
REQ-007 In DATA, for reads, rdata SHALL capture m_DO if m_OE=1, else 8'hFF; for writes, rdata SHALL be 8'h00.
REQ-008 In ACK, ack[gnt_id] SHALL be 1 for exactly that cycle; the other ack bit SHALL be 0.
REQ-009 req SHALL be ignored in ADDR, DATA and ACK; a req still high in the IDLE after ACK SHALL be treated as a new transaction.
REQ-010 Latency: the grant edge is t; ack SHALL be high from t+2 to t+3; without lock, throughput SHALL be at most one transaction per 4 cycles.
REQ-011 A req dropped before completion (protocol violation) SHALL NOT abort the transaction in flight.

Reset
REQ-012 While rst=1, and asynchronously on its assertion, the block SHALL force state=IDLE, ack=0, rdata=0, gnt_id=0, m_cs=0, m_we_n=1, m_A=0, m_DI=0, round-robin pointer=1 (requester 0 wins first tie), lock counter=0.
REQ-013 Reset mid-transaction SHALL discard the transaction with no ack and no further m_cs pulse.

Configuration
REQ-014 With RIOT_ARB_LOCK_EN defined: if lock[gnt_id]=1 and req[gnt_id]=1 in ACK, the FSM SHALL go directly to ADDR for the same requester (3-cycle throughput), and the other req SHALL be ignored.
REQ-015 With RIOT_ARB_LOCK_EN defined: the lock counter SHALL increment per locked continuation; at LOCK_MAX it SHALL force ACK -> IDLE, reset to 0, and the pointer SHALL favour the other requester; the counter SHALL also clear on any unlocked return to IDLE.
REQ-016 Without RIOT_ARB_LOCK_EN: the lock port and lock counter SHALL be absent, and behaviour SHALL be exactly REQ-003..REQ-013.

Structure
REQ-017 Package riot_arb_pkg SHALL hold the FSM state enum (IDLE, ADDR, DATA, ACK), the RDATA_NOOE=8'hFF and RDATA_WR=8'h00 constants, and the requester-count constant 2.
REQ-018 A sub-module riot_arb_rr (2-input round-robin picker: req, last -> winner, valid) SHALL be instantiated once.

Verification
REQ-019 Single read: req=2'b01, rq_addr0=10'h3C0, m_DO=8'h5A, m_OE=1 -> one m_cs pulse with m_A=10'h3C0 and m_we_n=1; ack=2'b01 two cycles after grant; rdata=8'h5A.
REQ-020 Write: req=2'b10, rq_we_n[1]=0, rq_addr1=10'h0C4, rq_wdata1=8'hA5 -> m_cs pulse with m_we_n=0 and m_DI=8'hA5; ack=2'b10; rdata=8'h00.
REQ-021 Tie after reset: req=2'b11 held continuously -> grants in order 0,1,0,1; each ack one cycle; m_cs pulses 4 cycles apart.
REQ-022 Read with m_OE=0 -> rdata=8'hFF.
REQ-023 rst asserted during DATA -> immediate IDLE, no ack, m_cs=0; after release, req=2'b01 completes normally.
REQ-024 (RIOT_ARB_LOCK_EN) lock=2'b01, req=2'b11, LOCK_MAX=3 -> 4 consecutive requester-0 transactions 3 cycles apart, then requester 1 is granted.

Source files
------------

// File: rtl/riot_arb_pkg.sv
// Shared types and constants for the RIOT bus arbiter.
package riot_arb_pkg;

    localparam int         NUM_REQ    = 2;
    localparam logic [7:0] RDATA_NOOE = 8'hFF;  // read with no valid core data
    localparam logic [7:0] RDATA_WR   = 8'h00;  // returned on write completion

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ACK  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/riot_arb_rr.sv
// Two-input round-robin picker: a lone request wins, a tie goes to the
// requester that was not granted last.
module riot_arb_rr
    import riot_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic               winner,
    output logic               valid
);

    // Pure combinational pick; req[1] alone selects 1, req[0] alone selects 0
    always_comb begin
        valid  = |req;
        winner = req[1];
        if (req == 2'b11)
            winner = ~last;
    end

endmodule

// File: rtl/riot_bus_arbiter.sv
// Two-requester arbiter in front of the 6530 RIOT core.
// Each transaction walks IDLE -> ADDR -> DATA -> ACK, one phi2 cycle each.
// Optional feature macro: RIOT_ARB_LOCK_EN (locked back-to-back transfers).
module riot_bus_arbiter
    import riot_arb_pkg::*;
#(
    parameter logic [3:0] LOCK_MAX = 4'd15
) (
    input  logic               phi2,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rq_we_n,
    input  logic [9:0]         rq_addr0,
    input  logic [9:0]         rq_addr1,
    input  logic [7:0]         rq_wdata0,
    input  logic [7:0]         rq_wdata1,
    output logic [NUM_REQ-1:0] ack,
    output logic [7:0]         rdata,
    output logic               gnt_id,
    output logic               m_cs,
    output logic               m_we_n,
    output logic [9:0]         m_A,
    output logic [7:0]         m_DI,
    input  logic [7:0]         m_DO,
`ifdef RIOT_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] lock,
`endif
    input  logic               m_OE
);

    arb_state_t state, state_nxt;
    logic       rr_last;     // last granted requester, reset to 1 so 0 wins first tie
    logic       rr_winner;
    logic       rr_valid;
    logic       lat_we_n;
    logic       sel;
    logic       load;
    logic       lock_go;     // ACK continues straight into ADDR for the same requester

    riot_arb_rr u_rr (
        .req    (req),
        .last   (rr_last),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

`ifdef RIOT_ARB_LOCK_EN
    logic [3:0] lock_cnt;

    assign lock_go = (state == ACK) && lock[gnt_id] && req[gnt_id] &&
                     (lock_cnt != LOCK_MAX);

    // Count locked continuations; any return to IDLE (forced or not) clears it
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst)
            lock_cnt <= 4'd0;
        else if (state == ACK)
            lock_cnt <= lock_go ? lock_cnt + 4'd1 : 4'd0;
    end
`else
    assign lock_go = 1'b0;

    // LOCK_MAX only matters with the lock feature; keep it elaborated here
    if (LOCK_MAX == 4'd0) begin : g_lock_max_unused
    end
`endif

    // A locked continuation re-latches the current owner; otherwise the picker decides
    assign sel  = (state == IDLE) ? rr_winner : gnt_id;
    assign load = ((state == IDLE) && rr_valid) || lock_go;

    // State register
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; req is only looked at in IDLE (and ACK when locked)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rr_valid) state_nxt = ADDR;
            ADDR: state_nxt = DATA;
            DATA: state_nxt = ACK;
            ACK:  state_nxt = lock_go ? ADDR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant latch and read-data capture; a dropped req cannot abort the transfer
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            gnt_id   <= 1'b0;
            rr_last  <= 1'b1;
            lat_we_n <= 1'b1;
            m_A      <= 10'd0;
            m_DI     <= 8'd0;
            rdata    <= 8'd0;
        end else begin
            if (load) begin
                gnt_id   <= sel;
                rr_last  <= sel;
                lat_we_n <= rq_we_n[sel];
                m_A      <= sel ? rq_addr1  : rq_addr0;
                m_DI     <= sel ? rq_wdata1 : rq_wdata0;
            end
            if (state == DATA)
                rdata <= !lat_we_n ? RDATA_WR : (m_OE ? m_DO : RDATA_NOOE);
        end
    end

    // Bus strobes and completion pulse decode straight from state
    always_comb begin
        m_cs   = (state == ADDR);
        m_we_n = (state == ADDR) ? lat_we_n : 1'b1;
        ack    = (state == ACK) ? {gnt_id, ~gnt_id} : 2'b00;
    end

endmodule

// File: tb/tb_riot_bus_arbiter.sv
// Scoreboard bench for riot_bus_arbiter: stimulus pushes expected bus
// accesses and completions; a negedge monitor pops and compares them.
module tb_riot_bus_arbiter;

    logic       phi2 = 1'b0;
    logic       rst  = 1'b1;
    logic [1:0] req = 2'b00, rq_we_n = 2'b11;
    logic [9:0] rq_addr0 = '0, rq_addr1 = '0;
    logic [7:0] rq_wdata0 = '0, rq_wdata1 = '0, m_DO = '0;
    logic       m_OE = 1'b0;
    logic [1:0] ack;
    logic [7:0] rdata, m_DI;
    logic       gnt_id, m_cs, m_we_n;
    logic [9:0] m_A;

`ifdef RIOT_ARB_LOCK_EN
    logic [1:0] lock = 2'b00;
    riot_bus_arbiter #(.LOCK_MAX(4'd3)) dut (
        .phi2(phi2), .rst(rst), .req(req), .rq_we_n(rq_we_n),
        .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
        .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
        .ack(ack), .rdata(rdata), .gnt_id(gnt_id), .m_cs(m_cs),
        .m_we_n(m_we_n), .m_A(m_A), .m_DI(m_DI), .m_DO(m_DO),
        .lock(lock), .m_OE(m_OE));
`else
    riot_bus_arbiter dut (
        .phi2(phi2), .rst(rst), .req(req), .rq_we_n(rq_we_n),
        .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
        .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
        .ack(ack), .rdata(rdata), .gnt_id(gnt_id), .m_cs(m_cs),
        .m_we_n(m_we_n), .m_A(m_A), .m_DI(m_DI), .m_DO(m_DO),
        .m_OE(m_OE));
`endif

    always #5 phi2 = ~phi2;

    int cyc = 0;
    always @(posedge phi2) cyc <= cyc + 1;

    typedef struct {
        logic       id;
        logic       we_n;
        logic [9:0] addr;
        logic [7:0] wdata;
        int         gap;     // required cycles since previous m_cs, 0 = don't care
    } bus_t;
    typedef struct {
        logic [1:0] ack;
        logic [7:0] rdata;
    } ack_t;

    bus_t bus_q[$];
    ack_t ack_q[$];
    int   cs_q[$];
    bus_t be;
    ack_t ae;
    int   last_cs = -1;
    int   checks = 0, errors = 0, ack_seen = 0, cs_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: compare every bus strobe and every completion against the queues
    always @(negedge phi2) begin
        if (!rst) begin
            if (m_cs) begin
                cs_seen++;
                if (bus_q.size() == 0)
                    chk("unexpected_m_cs_qsize", bus_q.size(), 1);
                else begin
                    be = bus_q.pop_front();
                    chk("m_A", m_A, be.addr);
                    chk("m_we_n", m_we_n, be.we_n);
                    chk("gnt_id", gnt_id, be.id);
                    if (!be.we_n) chk("m_DI", m_DI, be.wdata);
                    if (be.gap != 0) chk("cs_gap", cyc - last_cs, be.gap);
                end
                last_cs = cyc;
                cs_q.push_back(cyc);
            end
            if (ack != 2'b00) begin
                ack_seen++;
                if (ack_q.size() == 0)
                    chk("unexpected_ack_qsize", ack_q.size(), 1);
                else begin
                    ae = ack_q.pop_front();
                    chk("ack", ack, ae.ack);
                    chk("rdata", rdata, ae.rdata);
                end
                if (cs_q.size() != 0) chk("ack_latency", cyc - cs_q.pop_front(), 2);
                else chk("ack_cs_qsize", cs_q.size(), 1);
            end
        end
    end

    task automatic wait_acks(input int k, input string nm);
        int target = ack_seen + k;
        int lim = 60;
        while (ack_seen < target && lim > 0) begin
            @(negedge phi2); #1;
            lim--;
        end
        chk(nm, ack_seen, target);
    endtask

    task automatic pulse_reset();
        @(negedge phi2); rst = 1'b1;
        @(negedge phi2); rst = 1'b0;
        @(negedge phi2);
    endtask

    initial begin
        int target;
        int lim;
        rst = 1'b1;
        repeat (3) @(negedge phi2);
        chk("rst_ack", ack, 2'b00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_gnt_id", gnt_id, 1'b0);
        chk("rst_m_cs", m_cs, 1'b0);
        chk("rst_m_we_n", m_we_n, 1'b1);
        chk("rst_m_A", m_A, 10'h000);
        chk("rst_m_DI", m_DI, 8'h00);
        rst = 1'b0;
        @(negedge phi2);

        // single read from requester 0
        rq_addr0 = 10'h3C0; rq_we_n = 2'b11; m_DO = 8'h5A; m_OE = 1'b1;
        bus_q.push_back('{1'b0, 1'b1, 10'h3C0, 8'h00, 0});
        ack_q.push_back('{2'b01, 8'h5A});
        req = 2'b01;
        wait_acks(1, "t_read_done");
        req = 2'b00;
        repeat (3) @(negedge phi2);

        // write from requester 1
        rq_we_n = 2'b01; rq_addr1 = 10'h0C4; rq_wdata1 = 8'hA5;
        bus_q.push_back('{1'b1, 1'b0, 10'h0C4, 8'hA5, 0});
        ack_q.push_back('{2'b10, 8'h00});
        req = 2'b10;
        wait_acks(1, "t_write_done");
        req = 2'b00; rq_we_n = 2'b11;
        repeat (3) @(negedge phi2);

        // read with no valid core data
        m_OE = 1'b0; rq_addr0 = 10'h155;
        bus_q.push_back('{1'b0, 1'b1, 10'h155, 8'h00, 0});
        ack_q.push_back('{2'b01, 8'hFF});
        req = 2'b01;
        wait_acks(1, "t_nooe_done");
        req = 2'b00;
        repeat (3) @(negedge phi2);

        // tie after reset: 0,1,0,1 spaced 4 cycles
        pulse_reset();
        m_OE = 1'b1; m_DO = 8'h33; rq_addr0 = 10'h100; rq_addr1 = 10'h200;
        bus_q.push_back('{1'b0, 1'b1, 10'h100, 8'h00, 0});
        bus_q.push_back('{1'b1, 1'b1, 10'h200, 8'h00, 4});
        bus_q.push_back('{1'b0, 1'b1, 10'h100, 8'h00, 4});
        bus_q.push_back('{1'b1, 1'b1, 10'h200, 8'h00, 4});
        ack_q.push_back('{2'b01, 8'h33});
        ack_q.push_back('{2'b10, 8'h33});
        ack_q.push_back('{2'b01, 8'h33});
        ack_q.push_back('{2'b10, 8'h33});
        req = 2'b11;
        wait_acks(4, "t_tie_done");
        req = 2'b00;
        repeat (3) @(negedge phi2);

        // reset during DATA discards the transfer
        m_DO = 8'h5A; rq_addr0 = 10'h2AA;
        bus_q.push_back('{1'b0, 1'b1, 10'h2AA, 8'h00, 0});
        target = cs_seen + 1;
        lim = 20;
        req = 2'b01;
        while (cs_seen < target && lim > 0) begin
            @(negedge phi2); #1;
            lim--;
        end
        chk("t_rst_cs_seen", cs_seen, target);
        @(posedge phi2); #2;
        rst = 1'b1; req = 2'b00;
        #1;
        chk("rst_mid_m_cs", m_cs, 1'b0);
        chk("rst_mid_ack", ack, 2'b00);
        chk("rst_mid_m_we_n", m_we_n, 1'b1);
        chk("rst_mid_m_A", m_A, 10'h000);
        chk("rst_mid_rdata", rdata, 8'h00);
        cs_q.delete();
        repeat (2) @(negedge phi2);
        rst = 1'b0;
        repeat (6) @(negedge phi2);
        bus_q.push_back('{1'b0, 1'b1, 10'h2AA, 8'h00, 0});
        ack_q.push_back('{2'b01, 8'h5A});
        req = 2'b01;
        wait_acks(1, "t_post_rst_done");
        req = 2'b00;
        repeat (3) @(negedge phi2);

`ifdef RIOT_ARB_LOCK_EN
        // locked requester 0: four transfers 3 apart, then forced release to 1
        pulse_reset();
        lock = 2'b01; m_DO = 8'h77;
        bus_q.push_back('{1'b0, 1'b1, 10'h2AA, 8'h00, 0});
        for (int i = 0; i < 3; i++) bus_q.push_back('{1'b0, 1'b1, 10'h2AA, 8'h00, 3});
        bus_q.push_back('{1'b1, 1'b1, 10'h200, 8'h00, 4});
        for (int i = 0; i < 4; i++) ack_q.push_back('{2'b01, 8'h77});
        ack_q.push_back('{2'b10, 8'h77});
        req = 2'b11;
        wait_acks(5, "t_lock_done");
        req = 2'b00; lock = 2'b00;
        repeat (3) @(negedge phi2);
`endif

        repeat (4) @(negedge phi2);
        chk("bus_q_drained", bus_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
